// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic stage: eight operations on WIDTH-bit operands with an
// optional accumulator as first operand, results queued in a 2-entry valid/ready buffer.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  localparam int EW = WIDTH + 3;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [EW-1:0]    mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] res;
  logic [EW-1:0]    entry;
  logic [EW-1:0]    head;
  logic [EW-1:0]    head_next;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign acc_eff = acc_clr ? '0 : acc;
  assign x       = acc_en ? acc_eff : a;

  always_comb begin
    res = '0;
    case (op_e'(op))
      OP_AND:  res = x & b;
      OP_OR:   res = x | b;
      OP_XOR:  res = x ^ b;
      OP_NAND: res = ~(x & b);
      OP_NOR:  res = ~(x | b);
      OP_XNOR: res = ~(x ^ b);
      OP_ANDN: res = x & ~b;
      OP_PASS: res = x;
      default: res = '0;
    endcase
  end

  // Entry layout: {parity, ones, zero, result}; flags are frozen at accept time.
  assign entry = {^res, &res, ~|res, res};

  // The head is kept in its own register so that an emptied buffer keeps
  // presenting the last result instead of a stale slot behind the read pointer.
  always_comb begin
    head_next = head;
    if (count == 2'd0) begin
      if (push) head_next = entry;
    end else if (pop) begin
      if (count == 2'd2)  head_next = mem[~rd_ptr];
      else if (push)      head_next = entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      head   <= {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}};
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      head <= head_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (push)    acc <= res;
    else if (acc_clr) acc <= '0;
  end

  assign result = head[WIDTH-1:0];
  assign zero   = head[WIDTH];
  assign ones   = head[WIDTH+1];
  assign parity = head[WIDTH+2];

endmodule
